inst_fetch_port: RTL
====================

# inst_fetch_port

Responder side of the CPU instruction-fetch port: answers `rom_ce_o`/`rom_addr_o` requests from the `cpu_riscv` top with a 32-bit word on `rom_data_i`. Instructions are backed by a byte-wide memory with variable latency. A one-word buffer serves repeat fetches in the same cycle. On a miss the block assembles the word little-endian over four byte reads and raises a stall request, which feeds the `ctrl` module as `stallreq_from_if`.

## Interface
Parameters:
- `ADDR_W`, default 17: byte-address width of the backing memory.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rom_ce_i` input 1: fetch enable, driven from the CPU's `rom_ce_o`.
- `rom_addr_i` input 32: fetch byte address, driven from the CPU's `rom_addr_o`.
- `rom_data_o` output 32: instruction word, driven to the CPU's `rom_data_i`.
- `stallreq_o` output 1: fetch not ready; goes to `ctrl`.
- `flush_i` input 1: invalidates the word buffer (used after program load).
- `mem_req_o` output 1: byte read request, one outstanding.
- `mem_addr_o` output `ADDR_W`: byte address of the request.
- `mem_rdata_i` input 8: read byte.
- `mem_rvalid_i` input 1: `mem_rdata_i` valid; exactly one pulse per request, at least 1 cycle after `mem_req_o`.

## Operation
- Word address: `rom_addr_i[ADDR_W-1:2]`. Bits [1:0] and bits above `ADDR_W` are ignored.
- Buffer registers: `buf_valid`, `buf_tag[ADDR_W-3:0]`, `buf_word[31:0]`.
- Hit condition: `rom_ce_i & buf_valid & (tag == addr[ADDR_W-1:2])`.
  - `rom_data_o = buf_word` combinationally.
  - `stallreq_o = 0`.
- `rom_ce_i = 0`: `rom_data_o = 0`, `stallreq_o = 0`.
- Miss (`rom_ce_i` and not hit): `rom_data_o = 0`, `stallreq_o = 1` combinationally, in the same cycle.
- FSM states and transitions:
  - IDLE: on miss, latch `base = addr[ADDR_W-1:2]` and set `idx = 0`; go to REQ. Any `mem_rvalid_i` seen in IDLE is ignored.
  - REQ: drive `mem_req_o = 1` and `mem_addr_o = {base, idx[1:0]}` for exactly one cycle; go to WAIT.
  - WAIT: `mem_req_o = 0`. On `mem_rvalid_i`, write `shift[8*idx +: 8] = mem_rdata_i`. If `idx == 3` go to FILL, else increment `idx` and go to REQ.
  - FILL: `buf_word <= shift`, `buf_tag <= base`, `buf_valid <= ~flush_seen`; go to IDLE.
- `stallreq_o` stays 1 in REQ, WAIT and FILL whenever `rom_ce_i = 1`; the hit/miss decision is made only in IDLE.
- `flush_i`:
  - clears `buf_valid` the next cycle;
  - if asserted during REQ, WAIT or FILL, it also sets `flush_seen`, so the in-flight fill completes but stores `buf_valid = 0`;
  - `flush_seen` clears in IDLE.
- Address change mid-fill: the fill completes to the latched `base`. The new address is then evaluated in IDLE and misses again.
- `rom_ce_i` dropping mid-fill: the fill completes normally.

## Timing
- Reset values: `rom_data_o = 0`, `stallreq_o = 0`, `mem_req_o = 0`, `mem_addr_o = 0`. Internally: FSM in IDLE, `buf_valid = 0`, `flush_seen = 0`, `idx = 0`.
- Reset mid-fill aborts immediately; a late `mem_rvalid_i` after reset is ignored.
- Hit latency: 0 cycles (combinational).
- Miss latency with `mem_rvalid_i` arriving 1 cycle after each request:
  - cycle 0: IDLE detects the miss;
  - cycles 1–8: REQ/WAIT ×4;
  - cycle 9: FILL;
  - cycle 10: hit, and `stallreq_o` falls.
  - `stallreq_o` is therefore high for 10 cycles. Each extra wait cycle per byte adds 1.
- `mem_req_o` is a single-cycle pulse; the next request never issues before the previous `mem_rvalid_i`.

## Structure
- Constants go in `defines.v`: `InstAddrBus`, `InstBus`, `ZeroWord`, and the 2-bit state encodings `FETCH_IDLE`, `FETCH_REQ`, `FETCH_WAIT`, `FETCH_FILL`.
- Single module. No sub-module is warranted; the byte assembler is 4 lines of register logic.
- The top level gains one wire: `stallreq_o` → `ctrl.stallreq_from_if`.

## Test plan
- Cold fetch: after reset, `rom_ce_i = 1`, `addr = 0x0`, memory returns bytes `13 05 10 00` with 1-cycle latency → `mem_addr_o` sequence 0,1,2,3; `stallreq_o` high for 10 cycles; then `rom_data_o = 0x00100513`.
- Repeat hit: hold `addr = 0x2` after the cold fetch → `rom_data_o = 0x00100513` combinationally, `stallreq_o = 0`, no `mem_req_o`.
- Next word with 3-cycle memory latency: `addr = 0x4` → `mem_addr_o` sequence 4,5,6,7; `stallreq_o` high for 18 cycles.
- Flush during fill: assert `flush_i` in the cycle of the 2nd WAIT → fill completes and returns to IDLE; the same address misses again and re-issues 4 requests.
- Reset mid-fill: `rst` during the 3rd REQ → next cycle `mem_req_o = 0` and state is IDLE; a stray `mem_rvalid_i` is ignored; the fetch of 0x0 afterwards misses.
- `rom_ce_i = 0` with a valid buffer → `rom_data_o = 0`, `stallreq_o = 0`, no memory traffic.

Source files
------------

// File: rtl/inst_fetch_port_pkg.sv
// Shared constants for the instruction-fetch responder: bus widths, fetch FSM
// encodings and the byte-lane insert helper used by the word assembler.
package inst_fetch_port_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_WAIT = 2'd2;
    localparam logic [1:0] FETCH_FILL = 2'd3;

    // Little-endian placement: lane 0 is the lowest-addressed byte.
    function automatic logic [InstBus-1:0] insert_byte(
        input logic [InstBus-1:0] word,
        input logic [1:0]         lane,
        input logic [7:0]         data
    );
        logic [InstBus-1:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/inst_fetch_port.sv
// Instruction-fetch responder: one-word buffer in front of a byte-wide memory
// with variable latency; misses assemble a word over four byte reads.
//
// state      | meaning
// FETCH_IDLE | hit/miss evaluated; a miss latches the word address
// FETCH_REQ  | one-cycle byte read request for lane idx
// FETCH_WAIT | waiting for the byte; lane 3 completes the word
// FETCH_FILL | write assembled word into the buffer
module inst_fetch_port
    import inst_fetch_port_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstBus-1:0]     rom_data_o,
    output logic                   stallreq_o,
    input  logic                   flush_i,
    output logic                   mem_req_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [7:0]             mem_rdata_i,
    input  logic                   mem_rvalid_i
);

    localparam int TAG_W = ADDR_W - 2;

    fetch_state_t       state_q, state_d;
    logic [TAG_W-1:0]   base_q, base_d;
    logic [1:0]         idx_q, idx_d;
    logic [InstBus-1:0] shift_q, shift_d;
    logic               buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]   buf_tag_q, buf_tag_d;
    logic [InstBus-1:0] buf_word_q, buf_word_d;
    logic               flush_seen_q, flush_seen_d;

    logic [TAG_W-1:0]   word_addr;
    logic               hit;
    logic               miss;

    assign word_addr = rom_addr_i[ADDR_W-1:2];

    // Byte offset and bits above the memory window never select a word.
    generate
        if (ADDR_W < InstAddrBus) begin : g_hi_bits
            logic unused_addr_bits;
            assign unused_addr_bits = ^{rom_addr_i[InstAddrBus-1:ADDR_W], rom_addr_i[1:0]};
        end else begin : g_no_hi_bits
            logic unused_addr_bits;
            assign unused_addr_bits = ^rom_addr_i[1:0];
        end
    endgenerate

    always_comb begin
        hit  = (state_q == FETCH_IDLE) && rom_ce_i && buf_valid_q && (buf_tag_q == word_addr);
        miss = (state_q == FETCH_IDLE) && rom_ce_i && !hit;

        rom_data_o = hit ? buf_word_q : ZeroWord;
        stallreq_o = rom_ce_i && !hit;

        mem_req_o  = (state_q == FETCH_REQ);
        mem_addr_o = mem_req_o ? {base_q, idx_q} : '0;
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_word_d   = buf_word_q;
        flush_seen_d = flush_seen_q;

        if (flush_i) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            FETCH_IDLE: begin
                flush_seen_d = 1'b0;
                if (miss) begin
                    base_d  = word_addr;
                    idx_d   = 2'd0;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (flush_i) flush_seen_d = 1'b1;
                state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (flush_i) flush_seen_d = 1'b1;
                if (mem_rvalid_i) begin
                    shift_d = insert_byte(shift_q, idx_q, mem_rdata_i);
                    if (idx_q == 2'd3) begin
                        state_d = FETCH_FILL;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = FETCH_REQ;
                    end
                end
            end
            FETCH_FILL: begin
                // A flush landing on the fill cycle itself must also win.
                buf_word_d   = shift_q;
                buf_tag_d    = base_q;
                buf_valid_d  = !(flush_seen_q || flush_i);
                flush_seen_d = flush_seen_q || flush_i;
                state_d      = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            base_q       <= '0;
            idx_q        <= 2'd0;
            shift_q      <= ZeroWord;
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= '0;
            buf_word_q   <= ZeroWord;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            buf_word_q   <= buf_word_d;
            flush_seen_q <= flush_seen_d;
        end
    end

endmodule
